// File: rtl/regpair_xfer.sv
// regpair_xfer -- moves a 16-bit register pair to or from byte-wide memory.
//
// Operations (i_op):
//   00 LOAD  : pair <- mem[ptr], mem[ptr+1]        (address from i_ptr_pair)
//   01 STORE : mem[ptr], mem[ptr+1] <- pair        (address from i_ptr_pair)
//   10 PUSH  : SP -= 2, then mem[SP], mem[SP+1] <- pair
//   11 POP   : pair <- mem[SP], mem[SP+1], then SP += 2
// Transfers are little-endian: the even register goes to the lower address.
// Pair 4 is SP, which is held in registers 8 (low) and 9 (high).
//
// Ports:
//   i_clk, i_reset_n            clock, asynchronous active-low reset
//   i_start, i_op, i_pair,
//   i_ptr_pair                  command (sampled only while idle)
//   o_busy, o_done              status; o_done pulses for one cycle
//   o_reg_addr_sel / i_reg_addr register-file pair address port
//   o_reg_rd_sel / i_reg_rd     register-file single-byte read port
//   o_load, o_load_sel,
//   o_load_dat                  register-file write port
//   o_mem_*, i_mem_dat,
//   i_mem_ack                   byte-wide memory request/acknowledge
module regpair_xfer (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic        i_start,
    input  logic [1:0]  i_op,
    input  logic [2:0]  i_pair,
    input  logic [2:0]  i_ptr_pair,
    output logic        o_busy,
    output logic        o_done,
    output logic [2:0]  o_reg_addr_sel,
    input  logic [15:0] i_reg_addr,
    output logic [3:0]  o_reg_rd_sel,
    input  logic [7:0]  i_reg_rd,
    output logic        o_load,
    output logic [3:0]  o_load_sel,
    output logic [7:0]  o_load_dat,
    output logic        o_mem_req,
    output logic        o_mem_we,
    output logic [15:0] o_mem_addr,
    output logic [7:0]  o_mem_dat,
    input  logic [7:0]  i_mem_dat,
    input  logic        i_mem_ack
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_BYTE0 = 3'd1;
    localparam logic [2:0] S_BYTE1 = 3'd2;
    localparam logic [2:0] S_SPLO  = 3'd3;
    localparam logic [2:0] S_SPHI  = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;

    localparam logic [1:0] OP_LOAD  = 2'b00;
    localparam logic [1:0] OP_STORE = 2'b01;
    localparam logic [1:0] OP_PUSH  = 2'b10;
    localparam logic [1:0] OP_POP   = 2'b11;

    localparam logic [2:0] SP_PAIR   = 3'd4;
    localparam logic [3:0] SP_LO_REG = 4'd8;
    localparam logic [3:0] SP_HI_REG = 4'd9;

    logic [2:0]  state_q, state_d;
    logic [1:0]  op_q, op_d;
    logic [2:0]  pair_q, pair_d;
    logic [15:0] base_q, base_d;

    logic        accept;
    logic        is_write;
    logic        byte_hi;
    logic [3:0]  byte_reg;
    logic [15:0] new_sp;

    assign accept   = (state_q == S_IDLE) && i_start;
    assign is_write = (op_q == OP_STORE) || (op_q == OP_PUSH);
    assign byte_hi  = (state_q == S_BYTE1);
    assign byte_reg = {pair_q, byte_hi};
    // PUSH pre-decremented the base at accept time, so the stored base is
    // already the new SP; POP moves SP past the two bytes just read.
    assign new_sp   = (op_q == OP_PUSH) ? base_q : base_q + 16'd2;

    // Command capture: operand registers only change when a command is
    // accepted, so they need no reset (outputs ignore them while idle).
    always_comb begin
        op_d   = op_q;
        pair_d = pair_q;
        base_d = base_q;
        if (accept) begin
            op_d   = i_op;
            pair_d = i_pair;
            base_d = (i_op == OP_PUSH) ? i_reg_addr - 16'd2 : i_reg_addr;
        end
    end

    always_ff @(posedge i_clk) begin
        op_q   <= op_d;
        pair_q <= pair_d;
        base_q <= base_d;
    end

    // Sequencer and all outputs: everything is decoded from state, so an
    // asynchronous reset drops every strobe and bus to zero immediately.
    always_comb begin
        state_d        = state_q;
        o_busy         = (state_q != S_IDLE);
        o_done         = 1'b0;
        o_reg_addr_sel = 3'd0;
        o_reg_rd_sel   = 4'd0;
        o_load         = 1'b0;
        o_load_sel     = 4'd0;
        o_load_dat     = 8'd0;
        o_mem_req      = 1'b0;
        o_mem_we       = 1'b0;
        o_mem_addr     = 16'd0;
        o_mem_dat      = 8'd0;

        case (state_q)
            S_IDLE: begin
                // PUSH/POP always address through SP; op[1] marks them.
                o_reg_addr_sel = i_op[1] ? SP_PAIR : i_ptr_pair;
                if (i_start) begin
                    state_d = S_BYTE0;
                end
            end

            S_BYTE0, S_BYTE1: begin
                o_mem_req  = 1'b1;
                o_mem_we   = is_write;
                o_mem_addr = base_q + {15'd0, byte_hi};
                if (is_write) begin
                    o_reg_rd_sel = byte_reg;
                    o_mem_dat    = i_reg_rd;
                end else if (i_mem_ack) begin
                    o_load     = 1'b1;
                    o_load_sel = byte_reg;
                    o_load_dat = i_mem_dat;
                end
                if (i_mem_ack) begin
                    if (!byte_hi) begin
                        state_d = S_BYTE1;
                    end else begin
                        state_d = op_q[1] ? S_SPLO : S_DONE;
                    end
                end
            end

            S_SPLO: begin
                o_load     = 1'b1;
                o_load_sel = SP_LO_REG;
                o_load_dat = new_sp[7:0];
                state_d    = S_SPHI;
            end

            S_SPHI: begin
                o_load     = 1'b1;
                o_load_sel = SP_HI_REG;
                o_load_dat = new_sp[15:8];
                state_d    = S_DONE;
            end

            S_DONE: begin
                o_done  = 1'b1;
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

endmodule

// File: doc/regpair_xfer.md
REGPAIR_XFER -- requirements
Module: regpair_xfer

Interface
REQ-001 SHALL have port i_clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-002 SHALL have port i_reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL have port i_start, input, 1 bit: command strobe, sampled only in IDLE.
REQ-004 SHALL have port i_op, input, 2 bits: 00 LOAD, 01 STORE, 10 PUSH, 11 POP.
REQ-005 SHALL have port i_pair, input, 3 bits: data register pair (0 AB, 1 CD, 2 EF, 3 GH, 4 SP, 5 PC).
REQ-006 SHALL have port i_ptr_pair, input, 3 bits: address pair for LOAD/STORE; ignored for PUSH/POP, which use pair 4 (SP).
REQ-007 SHALL have port o_busy, output, 1 bit: high in every non-IDLE state.
REQ-008 SHALL have port o_done, output, 1 bit: one-cycle completion pulse.
REQ-009 SHALL have port o_reg_addr_sel, output, 3 bits: pair select toward the register file address output.
REQ-010 SHALL have port i_reg_addr, input, 16 bits: selected pair value, {odd reg, even reg}.
REQ-011 SHALL have port o_reg_rd_sel, output, 4 bits: single register select toward a register file read port.
REQ-012 SHALL have port i_reg_rd, input, 8 bits: selected register value.
REQ-013 SHALL have ports o_load (1 bit), o_load_sel (4 bits), o_load_dat (8 bits), all outputs: register file write strobe, register index, data.
REQ-014 SHALL have ports o_mem_req (out, 1), o_mem_we (out, 1), o_mem_addr (out, 16), o_mem_dat (out, 8), i_mem_dat (in, 8), i_mem_ack (in, 1): byte-wide memory handshake.

Function
REQ-015 SHALL implement states IDLE, BYTE0, BYTE1, SPLO, SPHI, DONE.
REQ-016 In IDLE, o_reg_addr_sel SHALL equal i_ptr_pair for LOAD/STORE and 4 for PUSH/POP (combinational).
REQ-017 On i_start in IDLE, SHALL latch op, pair and base address: i_reg_addr for LOAD/STORE/POP, i_reg_addr-2 (mod 2^16) for PUSH; next state BYTE0.
REQ-018 i_start SHALL be ignored while o_busy is high; no queuing.
REQ-019 Byte order SHALL be little-endian: BYTE0 accesses base (register {pair,0}), BYTE1 accesses base+1 mod 2^16 (register {pair,1}).
REQ-020 In BYTE0/BYTE1, o_mem_req SHALL be high with o_mem_addr, o_mem_we (1 for STORE/PUSH) and o_mem_dat stable until the cycle i_mem_ack is sampled high; the state advances on that edge.
REQ-021 For STORE/PUSH, o_reg_rd_sel SHALL be {pair,0} in BYTE0, {pair,1} in BYTE1; o_mem_dat SHALL equal i_reg_rd.
REQ-022 For LOAD/POP, in the ack cycle o_load SHALL be 1, o_load_sel the target register, o_load_dat = i_mem_dat.
REQ-023 After BYTE1: LOAD/STORE go to DONE; PUSH/POP go to SPLO.
REQ-024 SPLO/SPHI SHALL each take one cycle, writing the new SP low byte to register 8 and high byte to register 9 via o_load; new SP = base for PUSH, base+2 mod 2^16 for POP.
REQ-025 POP with i_pair = 4 SHALL leave SP = old SP+2 (SP update overrides loaded data).
REQ-026 DONE SHALL last one cycle with o_done = 1, then IDLE; no memory wait means LOAD/STORE take 3 cycles, PUSH/POP 5.
REQ-027 o_mem_req and o_load SHALL never be high together except in LOAD/POP ack cycles.

Reset
REQ-028 While i_reset_n is low: state IDLE; o_busy, o_done, o_mem_req, o_mem_we, o_load = 0; o_mem_addr, o_mem_dat, o_load_sel, o_load_dat, o_reg_rd_sel = 0.
REQ-029 Reset mid-transfer SHALL abort immediately; register writes already performed remain; SP is not updated.

Verification
REQ-030 LOAD pair 0 via pair 1 = 0x1234, mem[0x1234]=0xAA, [0x1235]=0xBB, ack same cycle -> writes A=0xAA, B=0xBB, o_done in cycle 3.
REQ-031 STORE pair 2 (E=0x11, F=0x22) via ptr 0xFFFF -> writes 0x11 to 0xFFFF, 0x22 to 0x0000 (wrap).
REQ-032 PUSH pair 3 (0x5566) with SP=0x0001 -> writes 0x66 at 0xFFFF, 0x55 at 0x0000; SP=0xFFFF; o_done in cycle 5.
REQ-033 POP pair 0 with SP=0x8000, ack delayed 3 cycles per byte -> request held stable, AB loaded, SP=0x8002.
REQ-034 i_start asserted while busy, then reset asserted during BYTE1 of a PUSH -> second command ignored; all outputs 0 immediately; SP unchanged.
